// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer for the 5-stage core: hazard stalls, EX redirects, trap
// entry behind outstanding memory, debug halt with drain, and a stall-cycle counter.
module pipe_hazard_ctrl #(
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1_raddr,
    input  logic [4:0]       id_rs2_raddr,
    input  logic             id_rs1_ren,
    input  logic             id_rs2_ren,
    input  logic [4:0]       ex_rd_waddr,
    input  logic             ex_is_load,
    input  logic             ex_jump,
    input  logic [31:0]      ex_jump_addr,
    input  logic             mdu_busy,
    input  logic             mem_busy,
    input  logic             trap_req,
    input  logic [31:0]      trap_addr,
    input  logic             halt_req,
    input  logic             resume_req,
    output logic             stall_pc,
    output logic             stall_ifid,
    output logic             stall_idex,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic             flush_exmem,
    output logic             redirect_valid,
    output logic [31:0]      redirect_addr,
    output logic             trap_ack,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_TRAP_WAIT = 2'd1,
        ST_DRAIN     = 2'd2,
        ST_HALTED    = 2'd3
    } state_e;

    localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES - 1);

    state_e           state_q, state_d;
    logic [31:0]      trap_addr_q, trap_addr_d;
    logic [3:0]       drain_q, drain_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic rs1_hit, rs2_hit, load_use;

    logic        s_pc, s_ifid, s_idex;
    logic        f_ifid, f_idex, f_exmem;
    logic        rv, ack, hlt;
    logic [31:0] ra;

    assign rs1_hit  = id_rs1_ren && (id_rs1_raddr == ex_rd_waddr);
    assign rs2_hit  = id_rs2_ren && (id_rs2_raddr == ex_rd_waddr);
    assign load_use = ex_is_load && (ex_rd_waddr != 5'd0) && (rs1_hit || rs2_hit);

    // State register, trap vector latch, drain counter and stall counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_RUN;
            trap_addr_q <= '0;
            drain_q     <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            trap_addr_q <= trap_addr_d;
            drain_q     <= drain_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        trap_addr_d = trap_addr_q;
        drain_d     = drain_q;
        cnt_d       = cnt_q + {{(CNT_W-1){1'b0}}, stall_pc};
        unique case (state_q)
            ST_RUN, ST_DRAIN: begin
                // A trap pre-empts everything, including a drain already in progress.
                if (trap_req) begin
                    if (mem_busy) begin
                        state_d     = ST_TRAP_WAIT;
                        trap_addr_d = trap_addr;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else if (state_q == ST_DRAIN) begin
                    if (drain_q != 4'd0) begin
                        drain_d = drain_q - 4'd1;
                    end else if (!mem_busy && !mdu_busy) begin
                        state_d = ST_HALTED;
                    end
                end else if (!ex_jump && !mdu_busy && !load_use && halt_req) begin
                    drain_d = DRAIN_INIT;
                    state_d = ST_DRAIN;
                end
            end
            ST_TRAP_WAIT: begin
                if (!mem_busy) begin
                    state_d = ST_RUN;
                end
            end
            ST_HALTED: begin
                if (resume_req) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_comb begin
        s_pc    = 1'b0;
        s_ifid  = 1'b0;
        s_idex  = 1'b0;
        f_ifid  = 1'b0;
        f_idex  = 1'b0;
        f_exmem = 1'b0;
        rv      = 1'b0;
        ra      = '0;
        ack     = 1'b0;
        hlt     = 1'b0;
        unique case (state_q)
            ST_RUN, ST_DRAIN: begin
                if (trap_req && !mem_busy) begin
                    rv      = 1'b1;
                    ra      = trap_addr;
                    f_ifid  = 1'b1;
                    f_idex  = 1'b1;
                    f_exmem = 1'b1;
                    ack     = 1'b1;
                end else if (trap_req) begin
                    s_pc   = 1'b1;
                    s_ifid = 1'b1;
                    f_idex = 1'b1;
                end else if (state_q == ST_DRAIN) begin
                    s_pc   = 1'b1;
                    f_ifid = 1'b1;
                end else if (ex_jump) begin
                    rv     = 1'b1;
                    ra     = ex_jump_addr;
                    f_ifid = 1'b1;
                    f_idex = 1'b1;
                end else if (mdu_busy) begin
                    s_pc    = 1'b1;
                    s_ifid  = 1'b1;
                    s_idex  = 1'b1;
                    f_exmem = 1'b1;
                end else if (load_use) begin
                    // One bubble suffices: the load leaves EX on the next edge.
                    s_pc   = 1'b1;
                    s_ifid = 1'b1;
                    f_idex = 1'b1;
                end else if (halt_req) begin
                    s_pc   = 1'b1;
                    f_ifid = 1'b1;
                end
            end
            ST_TRAP_WAIT: begin
                if (mem_busy) begin
                    s_pc   = 1'b1;
                    s_ifid = 1'b1;
                    f_idex = 1'b1;
                end else begin
                    rv      = 1'b1;
                    ra      = trap_addr_q;
                    f_ifid  = 1'b1;
                    f_idex  = 1'b1;
                    f_exmem = 1'b1;
                    ack     = 1'b1;
                end
            end
            ST_HALTED: begin
                hlt    = 1'b1;
                s_pc   = 1'b1;
                f_ifid = 1'b1;
            end
            default: begin
                hlt = 1'b0;
            end
        endcase
    end

    // Flush wins over stall on the same register; everything is quiet in reset.
    assign stall_pc       = rst & s_pc;
    assign stall_ifid     = rst & s_ifid & ~f_ifid;
    assign stall_idex     = rst & s_idex & ~f_idex;
    assign flush_ifid     = rst & f_ifid;
    assign flush_idex     = rst & f_idex;
    assign flush_exmem    = rst & f_exmem;
    assign redirect_valid = rst & rv;
    assign redirect_addr  = rst ? ra : 32'd0;
    assign trap_ack       = rst & ack;
    assign halted         = rst & hlt;
    assign stall_cnt      = cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios then randomized traffic, all
// checked against a behavioural model of the sequencing rules.
module tb_pipe_hazard_ctrl;
  localparam int DRAIN_CYCLES = 3;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] id_rs1_raddr, id_rs2_raddr, ex_rd_waddr;
  logic id_rs1_ren, id_rs2_ren, ex_is_load, ex_jump;
  logic [31:0] ex_jump_addr, trap_addr;
  logic mdu_busy, mem_busy, trap_req, halt_req, resume_req;
  logic stall_pc, stall_ifid, stall_idex, flush_ifid, flush_idex, flush_exmem;
  logic redirect_valid, trap_ack, halted;
  logic [31:0] redirect_addr;
  logic [CNT_W-1:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  // behavioural model state
  bit m_wait;
  int m_drain;
  bit m_halt;
  logic [31:0] m_latch;
  int m_cnt;
  bit cnt_known = 1'b0;
  logic [8:0] last_e;
  logic [8:0] exp_q[$];
  logic [31:0] addr_q[$];

  pipe_hazard_ctrl #(.DRAIN_CYCLES(DRAIN_CYCLES), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_rs1_raddr(id_rs1_raddr), .id_rs2_raddr(id_rs2_raddr),
    .id_rs1_ren(id_rs1_ren), .id_rs2_ren(id_rs2_ren),
    .ex_rd_waddr(ex_rd_waddr), .ex_is_load(ex_is_load),
    .ex_jump(ex_jump), .ex_jump_addr(ex_jump_addr),
    .mdu_busy(mdu_busy), .mem_busy(mem_busy),
    .trap_req(trap_req), .trap_addr(trap_addr),
    .halt_req(halt_req), .resume_req(resume_req),
    .stall_pc(stall_pc), .stall_ifid(stall_ifid), .stall_idex(stall_idex),
    .flush_ifid(flush_ifid), .flush_idex(flush_idex), .flush_exmem(flush_exmem),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .trap_ack(trap_ack), .halted(halted), .stall_cnt(stall_cnt)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000 ns");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit model_load_use();
    bit hit1, hit2;
    hit1 = id_rs1_ren && (id_rs1_raddr == ex_rd_waddr);
    hit2 = id_rs2_ren && (id_rs2_raddr == ex_rd_waddr);
    return ex_is_load && (ex_rd_waddr != 0) && (hit1 || hit2);
  endfunction

  // Expected {stall_pc,stall_ifid,stall_idex,flush_ifid,flush_idex,flush_exmem,
  // redirect_valid,trap_ack,halted} for this cycle, then advance the model.
  task automatic model_cycle(output logic [8:0] e, output logic [31:0] ea);
    bit sp, si, sx, fi, fx, fm, rv, ta, h;
    {sp, si, sx, fi, fx, fm, rv, ta, h} = '0;
    ea = 32'd0;
    if (!rst) begin
      m_wait = 0; m_drain = -1; m_halt = 0; m_latch = 0; m_cnt = 0;
      cnt_known = 1'b1;
    end else begin
      if (m_wait) begin
        if (mem_busy) begin sp = 1; si = 1; fx = 1; end
        else begin rv = 1; ea = m_latch; fi = 1; fx = 1; fm = 1; ta = 1; m_wait = 0; end
      end else if (m_halt) begin
        h = 1; sp = 1; fi = 1;
        if (resume_req) m_halt = 0;
      end else if (trap_req) begin
        m_drain = -1;
        if (!mem_busy) begin rv = 1; ea = trap_addr; fi = 1; fx = 1; fm = 1; ta = 1; end
        else begin sp = 1; si = 1; fx = 1; m_latch = trap_addr; m_wait = 1; end
      end else if (m_drain >= 0) begin
        sp = 1; fi = 1;
        if (m_drain > 0) m_drain--;
        else if (!mem_busy && !mdu_busy) begin m_drain = -1; m_halt = 1; end
      end else if (ex_jump) begin
        rv = 1; ea = ex_jump_addr; fi = 1; fx = 1;
      end else if (mdu_busy) begin
        sp = 1; si = 1; sx = 1; fm = 1;
      end else if (model_load_use()) begin
        sp = 1; si = 1; fx = 1;
      end else if (halt_req) begin
        sp = 1; fi = 1; m_drain = DRAIN_CYCLES - 1;
      end
      if (sp) m_cnt = (m_cnt + 1) % (1 << CNT_W);
    end
    e = {sp, si, sx, fi, fx, fm, rv, ta, h};
  endtask

  // One clock: inputs already driven after a falling edge; check, then wait for the next one.
  task automatic cycle(input string tag);
    logic [8:0] e, got;
    logic [31:0] ea, eaddr;
    int c;
    bit ck;
    #1;
    ck = cnt_known;
    c = m_cnt;
    model_cycle(e, ea);
    last_e = e;
    exp_q.push_back(e);
    addr_q.push_back(ea);
    got = {stall_pc, stall_ifid, stall_idex, flush_ifid, flush_idex, flush_exmem,
           redirect_valid, trap_ack, halted};
    e = exp_q.pop_front();
    eaddr = addr_q.pop_front();
    check({tag, "/ctl"}, 32'(got), 32'(e));
    if (e[2]) check({tag, "/addr"}, redirect_addr, eaddr);
    if (ck) check({tag, "/cnt"}, 32'(stall_cnt), 32'(c[CNT_W-1:0]));
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 1; id_rs1_raddr = 0; id_rs2_raddr = 0; id_rs1_ren = 0; id_rs2_ren = 0;
    ex_rd_waddr = 0; ex_is_load = 0; ex_jump = 0; ex_jump_addr = 0;
    mdu_busy = 0; mem_busy = 0; trap_req = 0; trap_addr = 0;
    halt_req = 0; resume_req = 0;
  endtask

  task automatic load_use_setup(input logic [4:0] rd);
    ex_is_load = 1; ex_rd_waddr = rd;
    id_rs1_raddr = rd; id_rs1_ren = 1;
    id_rs2_raddr = 5'd1; id_rs2_ren = 1;
  endtask

  initial begin
    int base;
    m_drain = -1;
    idle();
    @(negedge clk);

    // reset with busy inputs active: everything quiet
    rst = 0; trap_req = 1; mdu_busy = 1; halt_req = 1;
    cycle("reset0");
    cycle("reset1");
    idle();
    cycle("post_reset");

    // load-use: one bubble, then the load has left EX
    load_use_setup(5'd5);
    #1 check("lu_stall_pc", 32'(stall_pc), 32'd1);
    cycle("load_use");
    ex_is_load = 0;
    cycle("load_use_done");
    load_use_setup(5'd0);
    cycle("load_use_x0");
    idle();

    // jump wins over a simultaneous load-use hazard
    load_use_setup(5'd7);
    ex_jump = 1; ex_jump_addr = 32'h0000_0100;
    #1 check("jmp_addr", redirect_addr, 32'h0000_0100);
    cycle("jump");
    idle();
    cycle("jump_after");

    // trap behind outstanding memory, jump during the wait ignored
    base = m_cnt;
    trap_req = 1; trap_addr = 32'h8000_0004; mem_busy = 1;
    cycle("trap_c1");
    trap_addr = 32'h1234_5678;
    cycle("trap_c2");
    ex_jump = 1; ex_jump_addr = 32'h0000_0200;
    cycle("trap_c3");
    ex_jump = 0;
    cycle("trap_c4");
    mem_busy = 0;
    #1 check("trap_ack_c5", 32'(trap_ack), 32'd1);
    check("trap_vec_c5", redirect_addr, 32'h8000_0004);
    cycle("trap_c5");
    idle();
    #1 check("trap_stalls", 32'(stall_cnt), 32'((base + 4) % (1 << CNT_W)));
    cycle("trap_after");

    // multi-cycle EX op for 5 cycles
    base = m_cnt;
    mdu_busy = 1;
    for (int i = 0; i < 5; i++) cycle("mdu");
    idle();
    #1 check("mdu_cnt_delta", 32'(stall_cnt), 32'((base + 5) % (1 << CNT_W)));
    cycle("mdu_after");

    // halt with drain, then resume
    halt_req = 1;
    cycle("halt_entry");
    cycle("drain1");
    cycle("drain2");
    #1 check("not_halted_yet", 32'(halted), 32'd0);
    cycle("drain3");
    #1 check("halted_c5", 32'(halted), 32'd1);
    cycle("halted");
    halt_req = 0; resume_req = 1;
    cycle("resume");
    resume_req = 0;
    #1 check("resumed", 32'(halted), 32'd0);
    cycle("run_again");

    // reset while waiting for memory abandons the trap with no ack
    trap_req = 1; trap_addr = 32'h0000_0040; mem_busy = 1;
    cycle("tw_enter");
    rst = 0;
    cycle("tw_reset");
    idle();
    #1 check("tw_no_ack", 32'(trap_ack), 32'd0);
    cycle("tw_after_reset");

    // 16 stall cycles from zero wrap the 4-bit counter back to zero
    mdu_busy = 1;
    for (int i = 0; i < 16; i++) cycle("wrap");
    idle();
    #1 check("cnt_wrap", 32'(stall_cnt), 32'd0);
    cycle("wrap_after");

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      id_rs1_raddr = 5'($urandom_range(0, 3));
      id_rs2_raddr = 5'($urandom_range(0, 3));
      id_rs1_ren = 1'($urandom_range(0, 1));
      id_rs2_ren = 1'($urandom_range(0, 1));
      ex_rd_waddr = 5'($urandom_range(0, 3));
      ex_is_load = 1'($urandom_range(0, 1));
      ex_jump = ($urandom_range(0, 7) == 0);
      ex_jump_addr = $urandom;
      mdu_busy = ($urandom_range(0, 5) == 0);
      mem_busy = ($urandom_range(0, 2) == 0);
      if (!trap_req && $urandom_range(0, 19) == 0) begin
        trap_req = 1;
        trap_addr = $urandom;
      end
      if ($urandom_range(0, 14) == 0) halt_req = ~halt_req;
      resume_req = ($urandom_range(0, 5) == 0);
      rst = ($urandom_range(0, 99) != 0);
      cycle("rand");
      if (last_e[1]) trap_req = 0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
